i2c_bus_arbiter: RTL and testbench

Two-requester round-robin arbiter and transaction sequencer in front of the I2C module. It picks one requester, presents that requester's byte to the I2C module, and raises the module's enable. It tracks the transaction through the module's busy flag and returns the read byte with a completion pulse. A watchdog aborts any transaction that hangs the bus.

---
 rtl/i2c_bus_arbiter_pkg.sv | 24 ++
 rtl/i2c_bus_arbiter_if.sv | 35 +++
 rtl/i2c_bus_arbiter_rr_pick.sv | 31 +++
 rtl/i2c_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_bus_arbiter_pkg.sv
//------------------------------------------------------------------------------
// i2c_arb_pkg
// Shared state encodings, watchdog default and requester indices.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } arb_state_t;

    localparam logic [19:0] TIMEOUT_DEFAULT = 20'd500000;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_arbiter_if.sv
//------------------------------------------------------------------------------
// i2c_bus_arbiter_if
// Requester handshakes plus the I2C module control/data lines.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface i2c_bus_arbiter_if;
    logic       Req0;
    logic       Req1;
    logic [7:0] Data0;
    logic [7:0] Data1;
    logic       Grant0;
    logic       Grant1;
    logic       Done0;
    logic       Done1;
    logic [7:0] RdData;
    logic       Error;
    logic       I2CEN;
    logic [7:0] I2CData;
    logic       I2CBusy;
    logic [7:0] I2CRdData;

    modport master (
        input  Req0, Req1, Data0, Data1, I2CBusy, I2CRdData,
        output Grant0, Grant1, Done0, Done1, RdData, Error, I2CEN, I2CData
    );

    modport slave (
        output Req0, Req1, Data0, Data1, I2CBusy, I2CRdData,
        input  Grant0, Grant1, Done0, Done1, RdData, Error, I2CEN, I2CData
    );
endinterface

`default_nettype wire

// File: rtl/i2c_bus_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// i2c_rr_pick
// Combinational two-way round-robin winner select.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_rr_pick
    import i2c_arb_pkg::*;
(
    input  wire logic i_req0,
    input  wire logic i_req1,
    input  wire logic i_last,
    output logic      o_valid,
    output logic      o_idx
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_idx   = REQ0;
        // On a tie the requester that did not own the bus last time wins
        if (i_req0 && i_req1) begin
            o_idx = ~i_last;
        end else if (i_req1) begin
            o_idx = REQ1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
//------------------------------------------------------------------------------
// i2c_bus_arbiter
// Round-robin arbiter and transaction sequencer with watchdog for an I2C module.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned     TW      = 20,
    parameter logic [TW-1:0]   TIMEOUT = TW'(TIMEOUT_DEFAULT)
)(
    input  wire logic          CLK,
    input  wire logic          RESET,
    i2c_bus_arbiter_if.master  bus
);

    localparam logic [TW-1:0] c_wd_one = {{(TW-1){1'b0}}, 1'b1};

    arb_state_t    r_state;
    logic          r_last;
    logic          r_owner;
    logic          r_abort;
    logic [TW-1:0] r_wd;
    logic          r_grant0;
    logic          r_grant1;
    logic          r_done0;
    logic          r_done1;
    logic          r_error;
    logic          r_i2c_en;
    logic [7:0]    r_i2c_data;
    logic [7:0]    r_rd_data;

    logic          w_pick_valid;
    logic          w_pick_idx;
    logic [TW-1:0] w_wd_next;
    logic          w_wd_hit;

    i2c_rr_pick u_pick (
        .i_req0  (bus.Req0),
        .i_req1  (bus.Req1),
        .i_last  (r_last),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Hit is judged on the post-increment value so FINISH is entered TIMEOUT cycles after launch
    assign w_wd_next = (r_wd == TIMEOUT) ? r_wd : r_wd + c_wd_one;
    assign w_wd_hit  = (w_wd_next == TIMEOUT);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_last     <= REQ1;
            r_owner    <= REQ0;
            r_abort    <= 1'b0;
            r_wd       <= '0;
            r_grant0   <= 1'b0;
            r_grant1   <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_error    <= 1'b0;
            r_i2c_en   <= 1'b0;
            r_i2c_data <= 8'h00;
            r_rd_data  <= 8'h00;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_wd <= '0;
                    if (w_pick_valid) begin
                        r_owner    <= w_pick_idx;
                        r_grant0   <= (w_pick_idx == REQ0);
                        r_grant1   <= (w_pick_idx == REQ1);
                        r_i2c_data <= (w_pick_idx == REQ1) ? bus.Data1 : bus.Data0;
                        r_i2c_en   <= 1'b1;
                        r_state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_wd <= w_wd_next;
                    if (bus.I2CBusy) begin
                        r_i2c_en <= 1'b0;
                        r_state  <= WAIT;
                    end else if (w_wd_hit) begin
                        r_i2c_en  <= 1'b0;
                        r_abort   <= 1'b1;
                        r_rd_data <= 8'h00;
                        r_state   <= FINISH;
                    end
                end
                WAIT: begin
                    r_wd <= w_wd_next;
                    if (!bus.I2CBusy) begin
                        r_rd_data <= bus.I2CRdData;
                        r_state   <= FINISH;
                    end else if (w_wd_hit) begin
                        r_abort   <= 1'b1;
                        r_rd_data <= 8'h00;
                        r_state   <= FINISH;
                    end
                end
                FINISH: begin
                    r_done0  <= (r_owner == REQ0);
                    r_done1  <= (r_owner == REQ1);
                    r_error  <= r_abort;
                    r_last   <= r_owner;
                    r_grant0 <= 1'b0;
                    r_grant1 <= 1'b0;
                    r_abort  <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Grant0  = r_grant0;
    assign bus.Grant1  = r_grant1;
    assign bus.Done0   = r_done0;
    assign bus.Done1   = r_done1;
    assign bus.Error   = r_error;
    assign bus.I2CEN   = r_i2c_en;
    assign bus.I2CData = r_i2c_data;
    assign bus.RdData  = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
//------------------------------------------------------------------------------
// tb_i2c_bus_arbiter
// Directed table-driven bench with a behavioural I2C busy/read-data responder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_bus_arbiter;

    typedef struct {
        logic       r0;
        logic       r1;
        logic [7:0] d0;
        logic [7:0] d1;
        int         mode;      // 0 normal, 1 never busy, 2 busy hangs
        logic [7:0] rd;
        logic       exp_idx;
        logic [7:0] exp_data;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         exp_lat;
        int         exp_en;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    i2c_bus_arbiter_if bus();

    i2c_bus_arbiter #(.TW(20), .TIMEOUT(20'd100)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // I2C module responder
    int         mode       = 0;
    logic [7:0] model_rd   = 8'h00;
    logic       model_kill = 1'b0;
    logic       m_busy     = 1'b0;
    logic [7:0] m_rd_reg   = 8'h00;
    logic       m_active   = 1'b0;
    int         m_cnt      = 0;

    assign bus.I2CBusy   = m_busy;
    assign bus.I2CRdData = m_rd_reg;

    always @(posedge CLK) begin
        #1;
        if (model_kill || RESET) begin
            m_active = 1'b0;
            m_cnt    = 0;
            m_busy   = 1'b0;
        end else if (!m_active) begin
            if (bus.I2CEN && mode != 1) begin
                m_active = 1'b1;
                m_cnt    = 1;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 3) begin
                m_busy = 1'b1;
            end else if (m_cnt == 43 && mode == 0) begin
                m_rd_reg = model_rd;
                m_busy   = 1'b0;
                m_active = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (!(bus.Done0 || bus.Done1) && lat < 300) begin
            @(negedge CLK);
            lat++;
        end
        check({name, "_done_seen"}, (bus.Done0 || bus.Done1), 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        int   en_cnt;
        logic got;
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge CLK);
        bus.Req0 = v.r0; bus.Req1 = v.r1; bus.Data0 = v.d0; bus.Data1 = v.d1;
        mode = v.mode; model_rd = v.rd;
        @(negedge CLK);
        check({nm, "_grant0"}, bus.Grant0, (v.exp_idx == 1'b0));
        check({nm, "_grant1"}, bus.Grant1, (v.exp_idx == 1'b1));
        check({nm, "_i2cdata"}, bus.I2CData, v.exp_data);
        lat = 0; en_cnt = 0; got = 1'b0;
        while (!got && lat < 300) begin
            if (bus.I2CEN) en_cnt++;
            @(negedge CLK);
            lat++;
            if (bus.Done0 || bus.Done1) got = 1'b1;
        end
        check({nm, "_done_seen"}, got, 1);
        check({nm, "_latency"}, lat, v.exp_lat);
        check({nm, "_en_cycles"}, en_cnt, v.exp_en);
        check({nm, "_done0"}, bus.Done0, (v.exp_idx == 1'b0));
        check({nm, "_done1"}, bus.Done1, (v.exp_idx == 1'b1));
        check({nm, "_rddata"}, bus.RdData, v.exp_rd);
        check({nm, "_error"}, bus.Error, v.exp_err);
        check({nm, "_grant_low"}, {bus.Grant0, bus.Grant1}, 0);
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        model_kill = 1'b1;
        @(negedge CLK);
        model_kill = 1'b0;
        check({nm, "_pulse_end"}, {bus.Done0, bus.Done1, bus.Error}, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int lat;
        int cnt;
        int g;
        logic [1:0] order;

        vecs[0] = '{1'b1, 1'b0, 8'hA4, 8'h00, 0, 8'h5C, 1'b0, 8'hA4, 8'h5C, 1'b0, 44, 3};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h3C, 0, 8'h91, 1'b1, 8'h3C, 8'h91, 1'b0, 44, 3};
        vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 0, 8'hE7, 1'b0, 8'h11, 8'hE7, 1'b0, 44, 3};
        vecs[3] = '{1'b1, 1'b1, 8'h33, 8'h44, 0, 8'h08, 1'b1, 8'h44, 8'h08, 1'b0, 44, 3};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h5A, 1, 8'h99, 1'b1, 8'h5A, 8'h00, 1'b1, 101, 100};
        vecs[5] = '{1'b1, 1'b0, 8'h6E, 8'h00, 2, 8'hAB, 1'b0, 8'h6E, 8'h00, 1'b1, 101, 3};
        vecs[6] = '{1'b1, 1'b1, 8'h01, 8'h02, 0, 8'h4D, 1'b1, 8'h02, 8'h4D, 1'b0, 44, 3};

        bus.Req0 = 1'b0; bus.Req1 = 1'b0; bus.Data0 = 8'h00; bus.Data1 = 8'h00;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_grant", {bus.Grant0, bus.Grant1}, 0);
        check("rst_done", {bus.Done0, bus.Done1}, 0);
        check("rst_error", bus.Error, 0);
        check("rst_en", bus.I2CEN, 0);
        check("rst_i2cdata", bus.I2CData, 8'h00);
        check("rst_rddata", bus.RdData, 8'h00);

        // Tie fairness: both held for four transactions, Req0 first after reset
        bus.Req0 = 1'b1; bus.Req1 = 1'b1; bus.Data0 = 8'h10; bus.Data1 = 8'h20;
        mode = 0; model_rd = 8'h3A;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            g = 0;
            while (!(bus.Grant0 || bus.Grant1) && g < 10) begin
                @(negedge CLK);
                g++;
            end
            order = {bus.Grant1, bus.Grant0};
            check($sformatf("tie%0d_grant", k), order, (k % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("tie%0d_i2cdata", k), bus.I2CData, (k % 2 == 0) ? 8'h10 : 8'h20);
            wait_done($sformatf("tie%0d", k), lat);
            check($sformatf("tie%0d_done", k), {bus.Done1, bus.Done0}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (bus.Done0 || bus.Done1) cnt++;
            if (k == 3) begin
                bus.Req0 = 1'b0; bus.Req1 = 1'b0;
            end else begin
                @(negedge CLK);
            end
        end
        g = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (bus.Done0 || bus.Done1) cnt++;
            if (bus.Grant0 || bus.Grant1) g++;
        end
        check("tie_done_count", cnt, 4);
        check("tie_no_extra_grant", g, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Req drop and Data change during WAIT
        @(negedge CLK);
        bus.Req0 = 1'b1; bus.Data0 = 8'h6B; mode = 0; model_rd = 8'hC3;
        @(negedge CLK);
        check("drop_grant0", bus.Grant0, 1);
        repeat (4) @(negedge CLK);
        check("drop_en_low", bus.I2CEN, 0);
        bus.Req0 = 1'b0; bus.Data0 = 8'hFF;
        @(negedge CLK);
        check("drop_i2cdata", bus.I2CData, 8'h6B);
        check("drop_grant_held", bus.Grant0, 1);
        wait_done("drop", lat);
        check("drop_done0", bus.Done0, 1);
        check("drop_rddata", bus.RdData, 8'hC3);
        check("drop_error", bus.Error, 0);
        @(negedge CLK);

        // Asynchronous reset in WAIT
        bus.Req0 = 1'b1; bus.Data0 = 8'h77; model_rd = 8'h12;
        @(negedge CLK);
        check("rstw_grant0", bus.Grant0, 1);
        repeat (10) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        check("rstw_grant0_low", bus.Grant0, 0);
        check("rstw_en_low", bus.I2CEN, 0);
        check("rstw_done0_low", bus.Done0, 0);
        check("rstw_i2cdata", bus.I2CData, 8'h00);
        check("rstw_rddata", bus.RdData, 8'h00);
        bus.Req0 = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (bus.Done0 || bus.Done1 || bus.Grant0 || bus.Grant1) cnt++;
        end
        check("rstw_quiet", cnt, 0);
        bus.Req0 = 1'b1; bus.Req1 = 1'b1; bus.Data0 = 8'h5D; bus.Data1 = 8'hD5;
        @(negedge CLK);
        check("rstw_tie_grant", {bus.Grant1, bus.Grant0}, 2'b01);
        check("rstw_tie_i2cdata", bus.I2CData, 8'h5D);
        wait_done("rstw_tie", lat);
        check("rstw_tie_done0", bus.Done0, 1);
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        repeat (3) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
